// File: rtl/rb2_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rb2_access_ctrl_pkg
// Shared definitions for the RB2 receive register bank access controller:
//   - bank geometry (address width, data width, entry count)
//   - controller FSM state encoding
//   - bank command encoding driven on RB_RW
// No ports; imported by rr_arb2 and rb2_access_ctrl.
// -----------------------------------------------------------------------------
package rb2_access_ctrl_pkg;

    localparam int RB2_ADDR_W = 3;
    localparam int RB2_DATA_W = 18;
    localparam int RB2_DEPTH  = 8;

    // Controller states: WR and RD issue the bank command, RD_CAP waits for
    // the bank's one-cycle read latency and captures RB_Q.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WR     = 2'b01,
        RD     = 2'b10,
        RD_CAP = 2'b11
    } rb2_state_e;

    // Bank command encoding on RB_RW.
    localparam logic RB_READ  = 1'b1;
    localparam logic RB_WRITE = 1'b0;

endpackage

// File: rtl/rb2_access_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter (writer / reader) for the RB2 bank port.
// Grants are combinational and only produced while i_en is high; the pointer
// moves to the opposite side of whichever requester was granted, so under
// continuous contention the two sides alternate. After reset the writer is
// favoured.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   i_req_wr  in   writer eligible
//   i_req_rd  in   reader eligible
//   i_en      in   arbitration enabled this cycle (controller idle)
//   o_gnt_wr  out  writer wins this cycle
//   o_gnt_rd  out  reader wins this cycle
// -----------------------------------------------------------------------------
module rr_arb2
    import rb2_access_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_wr,
    input  logic i_req_rd,
    input  logic i_en,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    // 1 = reader has priority on the next tie, 0 = writer has priority.
    logic r_favour_rd;

    // Grant selection: a lone requester always wins; a tie goes to the
    // side the pointer favours.
    always_comb begin
        o_gnt_wr = 1'b0;
        o_gnt_rd = 1'b0;
        if (i_en) begin
            if (i_req_wr && (!i_req_rd || !r_favour_rd)) begin
                o_gnt_wr = 1'b1;
            end else if (i_req_rd) begin
                o_gnt_rd = 1'b1;
            end else begin
                o_gnt_wr = 1'b0;
                o_gnt_rd = 1'b0;
            end
        end else begin
            o_gnt_wr = 1'b0;
            o_gnt_rd = 1'b0;
        end
    end

    // Pointer update: after any grant the other side gets priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_favour_rd <= 1'b0;
        end else if (o_gnt_wr) begin
            r_favour_rd <= 1'b1;
        end else if (o_gnt_rd) begin
            r_favour_rd <= 1'b0;
        end else begin
            r_favour_rd <= r_favour_rd;
        end
    end

endmodule

// File: rtl/rb2_access_ctrl.sv
// -----------------------------------------------------------------------------
// rb2_access_ctrl
// Access controller for the 8 x 18-bit RB2 receive register bank. Shares the
// single bank port between the packet writer and the downstream reader,
// tracks which entries hold data written since reset/clr, refuses reads of
// unwritten entries, and raises a sticky done flag once every entry has been
// written. All outputs are registered.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   wr_req     in   write request (held with wr_addr/wr_data until wr_gnt)
//   wr_addr    in   write entry
//   wr_data    in   write payload
//   wr_gnt     out  one-cycle pulse: write issued to the bank
//   rd_req     in   read request (held with rd_addr until rd_gnt)
//   rd_addr    in   read entry
//   rd_gnt     out  one-cycle pulse: read issued to the bank
//   rd_valid   out  one-cycle pulse: rd_data holds the requested entry
//   rd_data    out  read result, held until the next rd_valid
//   clr        in   synchronous clear of valid_map and done
//   RB_RW      out  bank command (1 = read/idle, 0 = write)
//   RB_A       out  bank address
//   RB_D       out  bank write data
//   RB_Q       in   bank read data, one cycle after the read command
//   valid_map  out  per-entry written flags
//   done       out  sticky, all entries written
// -----------------------------------------------------------------------------
module rb2_access_ctrl
    import rb2_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = RB2_ADDR_W,
    parameter int DATA_W = RB2_DATA_W,
    parameter int DEPTH  = RB2_DEPTH
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr,
    output logic              RB_RW,
    output logic [ADDR_W-1:0] RB_A,
    output logic [DATA_W-1:0] RB_D,
    input  logic [DATA_W-1:0] RB_Q,
    output logic [DEPTH-1:0]  valid_map,
    output logic              done
);

    rb2_state_e        r_state;
    logic              r_rb_rw;
    logic [ADDR_W-1:0] r_rb_a;
    logic [DATA_W-1:0] r_rb_d;
    logic              r_wr_gnt;
    logic              r_rd_gnt;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [DEPTH-1:0]  r_valid_map;
    logic              r_done;

    rb2_state_e        w_state_nxt;
    logic              w_rb_rw_nxt;
    logic [ADDR_W-1:0] w_rb_a_nxt;
    logic [DATA_W-1:0] w_rb_d_nxt;
    logic              w_wr_gnt_nxt;
    logic              w_rd_gnt_nxt;
    logic              w_rd_valid_nxt;
    logic [DATA_W-1:0] w_rd_data_nxt;
    logic [DEPTH-1:0]  w_vm_base;
    logic [DEPTH-1:0]  w_vm_nxt;
    logic [DEPTH-1:0]  w_wr_bit;
    logic              w_done_nxt;

    logic              w_arb_en;
    logic              w_rd_elig;
    logic              w_gnt_wr;
    logic              w_gnt_rd;

    // Reads of entries not yet written since reset/clr are held off.
    assign w_rd_elig = rd_req & r_valid_map[rd_addr];
    assign w_arb_en  = (r_state == IDLE);

    // RB_A still holds the write address throughout the WR cycle.
    assign w_wr_bit  = {{(DEPTH-1){1'b0}}, 1'b1} << r_rb_a;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req_wr (wr_req),
        .i_req_rd (w_rd_elig),
        .i_en     (w_arb_en),
        .o_gnt_wr (w_gnt_wr),
        .o_gnt_rd (w_gnt_rd)
    );

    // Next-state and next-output decode for the bank sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_rb_rw_nxt    = RB_READ;
        w_rb_a_nxt     = r_rb_a;
        w_rb_d_nxt     = r_rb_d;
        w_wr_gnt_nxt   = 1'b0;
        w_rd_gnt_nxt   = 1'b0;
        w_rd_valid_nxt = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        case (r_state)
            IDLE: begin
                if (w_gnt_wr) begin
                    w_state_nxt  = WR;
                    w_rb_rw_nxt  = RB_WRITE;
                    w_rb_a_nxt   = wr_addr;
                    w_rb_d_nxt   = wr_data;
                    w_wr_gnt_nxt = 1'b1;
                end else if (w_gnt_rd) begin
                    w_state_nxt  = RD;
                    w_rb_a_nxt   = rd_addr;
                    w_rd_gnt_nxt = 1'b1;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            WR: begin
                w_state_nxt = IDLE;
            end
            RD: begin
                // Bank presents RB_Q during the following cycle.
                w_state_nxt = RD_CAP;
            end
            RD_CAP: begin
                w_state_nxt    = IDLE;
                w_rd_data_nxt  = RB_Q;
                w_rd_valid_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Valid map and done: clr is applied before the bit of a completing
    // write, so a clr during WR leaves exactly that entry marked.
    always_comb begin
        if (clr) begin
            w_vm_base = {DEPTH{1'b0}};
        end else begin
            w_vm_base = r_valid_map;
        end
        if (r_state == WR) begin
            w_vm_nxt = w_vm_base | w_wr_bit;
        end else begin
            w_vm_nxt = w_vm_base;
        end
        if (clr) begin
            w_done_nxt = &w_vm_nxt;
        end else begin
            w_done_nxt = r_done | (&w_vm_nxt);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rb_rw     <= RB_READ;
            r_rb_a      <= {ADDR_W{1'b0}};
            r_rb_d      <= {DATA_W{1'b0}};
            r_wr_gnt    <= 1'b0;
            r_rd_gnt    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= {DATA_W{1'b0}};
            r_valid_map <= {DEPTH{1'b0}};
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rb_rw     <= w_rb_rw_nxt;
            r_rb_a      <= w_rb_a_nxt;
            r_rb_d      <= w_rb_d_nxt;
            r_wr_gnt    <= w_wr_gnt_nxt;
            r_rd_gnt    <= w_rd_gnt_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_rd_data   <= w_rd_data_nxt;
            r_valid_map <= w_vm_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign RB_RW     = r_rb_rw;
    assign RB_A      = r_rb_a;
    assign RB_D      = r_rb_d;
    assign wr_gnt    = r_wr_gnt;
    assign rd_gnt    = r_rd_gnt;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign valid_map = r_valid_map;
    assign done      = r_done;

endmodule

// File: tb/tb_rb2_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rb2_access_ctrl
// Self-checking bench for rb2_access_ctrl. A transaction-level reference
// model (arbitration slots, per-entry shadow memory, due-times for pending
// read data and write commits) predicts every registered output each cycle.
// Directed scenarios are followed by a randomized request/clr phase.
// -----------------------------------------------------------------------------
module tb_rb2_access_ctrl;

    localparam int AW = 3;
    localparam int DW = 18;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = 3'd0;
    logic [DW-1:0] wr_data = 18'd0;
    logic          wr_gnt;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = 3'd0;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          clr = 1'b0;
    logic          RB_RW;
    logic [AW-1:0] RB_A;
    logic [DW-1:0] RB_D;
    logic [DW-1:0] rb_q;
    logic [DP-1:0] valid_map;
    logic          done;

    logic [DW-1:0] bank [DP];

    always #5 clk = ~clk;

    // Bank with one-cycle registered read.
    always @(posedge clk) begin
        if (RB_RW == 1'b0) bank[RB_A] <= RB_D;
        rb_q <= bank[RB_A];
    end

    rb2_access_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .clr(clr),
        .RB_RW(RB_RW), .RB_A(RB_A), .RB_D(RB_D), .RB_Q(rb_q),
        .valid_map(valid_map), .done(done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic          m_wr_gnt, m_rd_gnt, m_rd_valid, m_rb_rw, m_done;
    logic [AW-1:0] m_rb_a, m_cm_addr;
    logic [DW-1:0] m_rb_d, m_rd_data, m_rd_exp, m_cm_data;
    logic [DP-1:0] m_vm;
    logic [DW-1:0] m_shadow [DP];
    bit            m_favour_rd;
    int            edge_n = 0;
    int            m_next_free, m_rd_due, m_cm_edge;

    task automatic model_reset();
        m_wr_gnt = 1'b0; m_rd_gnt = 1'b0; m_rd_valid = 1'b0; m_rb_rw = 1'b1;
        m_done = 1'b0; m_rb_a = 3'd0; m_rb_d = 18'd0; m_rd_data = 18'd0;
        m_vm = 8'd0; m_favour_rd = 1'b0;
        m_next_free = 0; m_rd_due = -1; m_cm_edge = -1;
    endtask

    // Advance the model over one rising edge, using the inputs seen there.
    task automatic model_step();
        bit ew, er, pick_w;
        ew = wr_req;
        er = rd_req && m_vm[rd_addr];
        m_wr_gnt = 1'b0; m_rd_gnt = 1'b0; m_rd_valid = 1'b0; m_rb_rw = 1'b1;
        if (m_rd_due == edge_n) begin
            m_rd_valid = 1'b1; m_rd_data = m_rd_exp; m_rd_due = -1;
        end
        if (clr) begin
            m_vm = 8'd0; m_done = 1'b0;
        end
        if (m_cm_edge == edge_n) begin
            m_vm[m_cm_addr] = 1'b1; m_shadow[m_cm_addr] = m_cm_data; m_cm_edge = -1;
        end
        if (&m_vm) m_done = 1'b1;
        if (edge_n >= m_next_free && (ew || er)) begin
            pick_w = ew && (!er || !m_favour_rd);
            if (pick_w) begin
                m_wr_gnt = 1'b1; m_rb_rw = 1'b0; m_rb_a = wr_addr; m_rb_d = wr_data;
                m_cm_edge = edge_n + 1; m_cm_addr = wr_addr; m_cm_data = wr_data;
                m_next_free = edge_n + 2; m_favour_rd = 1'b1;
            end else begin
                m_rd_gnt = 1'b1; m_rb_a = rd_addr;
                m_rd_due = edge_n + 2; m_rd_exp = m_shadow[rd_addr];
                m_next_free = edge_n + 3; m_favour_rd = 1'b0;
            end
        end
    endtask

    // One clock: sample at the falling edge after the rising edge, compare all outputs.
    task automatic tick();
        @(negedge clk);
        edge_n++;
        if (!rst) model_reset();
        else model_step();
        chk("wr_gnt",    32'(wr_gnt),    32'(m_wr_gnt));
        chk("rd_gnt",    32'(rd_gnt),    32'(m_rd_gnt));
        chk("rd_valid",  32'(rd_valid),  32'(m_rd_valid));
        chk("rd_data",   32'(rd_data),   32'(m_rd_data));
        chk("RB_RW",     32'(RB_RW),     32'(m_rb_rw));
        chk("RB_A",      32'(RB_A),      32'(m_rb_a));
        chk("RB_D",      32'(RB_D),      32'(m_rb_d));
        chk("valid_map", 32'(valid_map), 32'(m_vm));
        chk("done",      32'(done),      32'(m_done));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit seen;
        seen = 1'b0;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (wr_gnt) seen = 1'b1;
        end
        wr_req = 1'b0;
        chk("wr_timeout", 32'(seen), 32'd1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int gap);
        bit g, v;
        int tg;
        g = 1'b0; v = 1'b0; tg = edge_n;
        rd_req = 1'b1; rd_addr = a;
        for (int i = 0; i < 20 && !g; i++) begin
            tick();
            if (rd_gnt) begin g = 1'b1; tg = edge_n; end
        end
        rd_req = 1'b0;
        for (int i = 0; i < 6 && !v; i++) begin
            tick();
            if (rd_valid) v = 1'b1;
        end
        chk("rd_gnt_timeout", 32'(g), 32'd1);
        chk("rd_valid_timeout", 32'(v), 32'd1);
        d = rd_data;
        gap = edge_n - tg;
    endtask

    task automatic drive_rand();
        if (wr_gnt) wr_req = 1'b0;
        if (!wr_req && $urandom_range(0, 3) == 0) begin
            wr_req = 1'b1; wr_addr = 3'($urandom); wr_data = 18'($urandom);
        end
        if (rd_gnt) rd_req = 1'b0;
        if (!rd_req && $urandom_range(0, 2) == 0) begin
            rd_req = 1'b1; rd_addr = 3'($urandom);
        end
        clr = ($urandom_range(0, 39) == 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        int gap, cnt, viol, last_side, n_w, n_r;

        // Reset state
        model_reset();
        tick(); tick();
        chk("rst_RB_RW", 32'(RB_RW), 32'd1);
        chk("rst_vm", 32'(valid_map), 32'd0);
        rst = 1'b1;
        tick();

        // Single write: addr 5, latency and one-cycle write command
        wr_req = 1'b1; wr_addr = 3'd5; wr_data = 18'h2A5A5;
        tick();
        chk("w5_gnt", 32'(wr_gnt), 32'd1);
        chk("w5_rw", 32'(RB_RW), 32'd0);
        chk("w5_a", 32'(RB_A), 32'd5);
        chk("w5_d", 32'(RB_D), 32'h2A5A5);
        wr_req = 1'b0;
        tick();
        chk("w5_rw_back", 32'(RB_RW), 32'd1);
        chk("w5_vm", 32'(valid_map), 32'h20);
        tick();

        // Read of an unwritten entry stalls, then proceeds after the write
        rd_req = 1'b1; rd_addr = 3'd3; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_gnt) cnt++;
        end
        chk("stall_no_gnt", 32'(cnt), 32'd0);
        do_write(3'd3, 18'h00011);
        do_read(3'd3, d, gap);
        chk("r3_data", 32'(d), 32'h00011);
        chk("r3_gap", 32'(gap), 32'd2);
        tick(); tick();

        // Contention: grants must alternate
        wr_req = 1'b1; wr_addr = 3'd6; wr_data = 18'($urandom);
        rd_req = 1'b1; rd_addr = 3'd5;
        viol = 0; last_side = 2; n_w = 0; n_r = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (wr_gnt) begin
                if (last_side == 0) viol++;
                last_side = 0; n_w++; wr_data = 18'($urandom);
            end
            if (rd_gnt) begin
                if (last_side == 1) viol++;
                last_side = 1; n_r++;
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;
        chk("alt_viol", 32'(viol), 32'd0);
        chk("alt_nw", 32'(n_w >= 2), 32'd1);
        chk("alt_nr", 32'(n_r >= 2), 32'd1);
        for (int i = 0; i < 4; i++) tick();

        // Fill all entries, done rises on the eighth write
        for (int a = 0; a < DP; a++) begin
            if (a == DP - 1) chk("done_pre", 32'(done), 32'd0);
            do_write(3'(a), 18'(a * 3));
        end
        tick();
        chk("done_set", 32'(done), 32'd1);
        chk("vm_full", 32'(valid_map), 32'hFF);
        for (int a = 0; a < DP; a++) begin
            do_read(3'(a), d, gap);
            chk("readback", 32'(d), 32'(a * 3));
        end
        tick();

        // clr coincident with the WR cycle of a write to addr 2
        wr_req = 1'b1; wr_addr = 3'd2; wr_data = 18'h3C3C3;
        tick();
        chk("clr_wgnt", 32'(wr_gnt), 32'd1);
        wr_req = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_vm", 32'(valid_map), 32'h04);
        chk("clr_done", 32'(done), 32'd0);
        tick();

        // Reset during RD_CAP
        rd_req = 1'b1; rd_addr = 3'd2;
        tick();
        chk("rc_gnt", 32'(rd_gnt), 32'd1);
        rd_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rc_rw", 32'(RB_RW), 32'd1);
        chk("rc_a", 32'(RB_A), 32'd0);
        chk("rc_d", 32'(RB_D), 32'd0);
        chk("rc_valid", 32'(rd_valid), 32'd0);
        chk("rc_data", 32'(rd_data), 32'd0);
        chk("rc_vm", 32'(valid_map), 32'd0);
        model_reset();
        tick();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rd_valid || rd_gnt || wr_gnt) cnt++;
        end
        chk("rc_no_pulse", 32'(cnt), 32'd0);

        // Randomized traffic with occasional clr
        for (int i = 0; i < 1500; i++) begin
            tick();
            drive_rand();
        end
        wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rb2_access_ctrl.md
Name: rb2_access_ctrl

Overview:
- Controller and arbiter for the 8-entry x 18-bit receive register bank (RB2).
- Shares the single bank port between two requesters:
  - Write requester: the serial packet receiver, one complete 3-bit-address + 18-bit-data packet per request.
  - Read requester: the downstream consumer.
- Tracks which entries hold fresh data, blocks reads of unwritten entries, and raises a sticky done flag once all 8 entries have been written.

Parameters:
- ADDR_W, 3, bank address width.
- DATA_W, 18, bank data width.
- DEPTH, 8, number of bank entries; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_req  in  1  write request; held high with wr_addr/wr_data stable until wr_gnt.
- wr_addr  in  ADDR_W  write target entry.
- wr_data  in  DATA_W  write payload.
- wr_gnt  out  1  one-cycle pulse: write accepted and issued to the bank.
- rd_req  in  1  read request; held high with rd_addr stable until rd_gnt.
- rd_addr  in  ADDR_W  read target entry.
- rd_gnt  out  1  one-cycle pulse: read accepted and issued to the bank.
- rd_valid  out  1  one-cycle pulse: rd_data holds the requested entry.
- rd_data  out  DATA_W  read result, held until the next rd_valid.
- clr  in  1  synchronous clear of valid_map and done.
- RB_RW  out  1  bank command: 1 = read/idle, 0 = write.
- RB_A  out  ADDR_W  bank address.
- RB_D  out  DATA_W  bank write data.
- RB_Q  in  DATA_W  bank read data; valid the cycle after a read command is on RB_A/RB_RW.
- valid_map  out  DEPTH  bit i set means entry i has been written since the last reset or clr.
- done  out  1  sticky; high when valid_map is all ones.

Behaviour:
- Reset values (rst low, asynchronous):
  - RB_RW=1; RB_A=0; RB_D=0.
  - wr_gnt=0; rd_gnt=0; rd_valid=0; rd_data=0.
  - valid_map=0; done=0.
  - FSM in IDLE; round-robin pointer favours write.
- All outputs are registered.
- FSM states: IDLE, WR, RD, RD_CAP.
- IDLE:
  - Evaluate eligible requests.
  - The writer is always eligible when wr_req=1.
  - The reader is eligible only when rd_req=1 and valid_map[rd_addr]=1. A read of an unwritten entry stalls with no grant.
  - Only writer eligible: go to WR.
  - Only reader eligible: go to RD.
  - Both eligible: round-robin. Grant the side not served last, then flip the pointer to the other side.
  - Neither eligible: stay in IDLE; RB_RW stays 1.
- WR (exactly 1 cycle):
  - RB_RW=0, RB_A=wr_addr, RB_D=wr_data, wr_gnt=1.
  - Set valid_map[wr_addr] on this edge.
  - Return to IDLE; RB_RW returns to 1 on the next edge.
- RD (1 cycle): RB_RW=1, RB_A=rd_addr, rd_gnt=1.
- RD_CAP (1 cycle): capture RB_Q into rd_data, pulse rd_valid, return to IDLE.
- Latencies:
  - Write: request seen in IDLE → wr_gnt 1 cycle later.
  - Read: rd_gnt 1 cycle after the request is seen; rd_valid 2 cycles after that.
- Throughput: one write per 2 cycles, or one read per 3 cycles.
- Back-to-back writes from a continuously asserted wr_req are legal. The requester must present the next packet after seeing wr_gnt.
- Rewriting an already-valid entry is allowed; data is overwritten and valid_map is unchanged.
- done:
  - Set on the edge where valid_map becomes all ones.
  - Stays set until clr or reset.
- clr:
  - Clears valid_map and done in IDLE, RD and RD_CAP.
  - clr coincident with a WR cycle: the clear applies first, then the written bit is set, so valid_map ends as a one-hot of wr_addr.
  - An in-flight read still completes.
- Reset mid-operation: all state is dropped immediately. No grant or valid pulse is emitted after reset release until a new request arrives.
- Requests changing before their grant are a protocol violation; behaviour is undefined.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W, DEPTH constants.
  - FSM state enum {IDLE, WR, RD, RD_CAP}.
  - RB_RW encodings RB_READ=1, RB_WRITE=0.
- One natural sub-module: rr_arb2, the 2-requester round-robin arbiter with pointer update on grant.

Test Plan:
- Write addr 5, data 18'h2A5A5 → wr_gnt 1 cycle after the request; RB_RW=0, RB_A=5, RB_D=18'h2A5A5 for exactly 1 cycle; valid_map=8'b0010_0000.
- Read addr 3 before it has been written → no rd_gnt for 10 cycles. Then write addr 3 = 18'h00011 → rd_gnt follows; rd_valid 2 cycles after rd_gnt with rd_data=18'h00011.
- wr_req and rd_req (valid addr) held together for 12 cycles → grants alternate W,R,W,R…; no two consecutive grants to the same side.
- Write all 8 addresses with data = addr*3 → done rises on the edge of the 8th write. Reading back each entry returns addr*3.
- clr pulsed in the same cycle as a WR to addr 2 → valid_map=8'b0000_0100, done=0.
- rst driven low during RD_CAP → all outputs at reset values immediately; no rd_valid after release.
